// File: rtl/stream_dedup_pkg.sv
// Shared types and sizing helpers for the stream de-duplicator.
// Holds the set FSM state type, default sizes and width functions.
package stream_dedup_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        CLOSED  = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 9;

    // Width able to hold the values 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Slot address width; never collapses to zero bits.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dedup_cam.sv
// Small CAM for stream_dedup: DEPTH value slots with valid bits.
// Ports: wr_en/wr_idx/wr_data write a slot, clear empties the table,
// key/hit is the parallel lookup against valid slots only.
// With STREAM_DEDUP_READBACK_EN: rd_addr -> rd_data/rd_hit slot read.
module dedup_cam
    import stream_dedup_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = cnt_width(DEPTH),
    parameter int AW     = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] key,
    output logic              hit
`ifdef STREAM_DEDUP_READBACK_EN
    ,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_hit
`endif
);

    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_vld;
    logic [DEPTH-1:0]  match_vec;

    // Only the valid bits need reset; an invalid slot never matches.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            ent_vld <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == CNT_W'(i)) begin
                    ent_vld[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == CNT_W'(i)) begin
                    ent_data[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = ent_vld[i] && (ent_data[i] == key);
        end
    end

    assign hit = |match_vec;

`ifdef STREAM_DEDUP_READBACK_EN
    // Out-of-range addresses decode to no slot and read as zero.
    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data = ent_data[i];
                rd_hit  = ent_vld[i];
            end
        end
    end
`endif

endmodule

// File: rtl/stream_dedup.sv
// Streaming duplicate remover: forwards first occurrences in order.
// Ports: in_* valid/ready input with in_last closing the set, out_*
// valid/ready output, clear restarts the set, unique_count/full/
// overflow/done report table status.  STREAM_DEDUP_READBACK_EN adds
// rd_addr/rd_data/rd_hit for reading stored slots in arrival order.
module stream_dedup
    import stream_dedup_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  unique_count,
    output logic              full,
    output logic              overflow,
    output logic              done
`ifdef STREAM_DEDUP_READBACK_EN
    ,
    input  logic [addr_width(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_hit
`endif
);

    state_t            state_q;
    state_t            state_d;
    logic              done_d;
    logic              done_q;
    logic [CNT_W-1:0]  count_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] data_q;
    logic              ovf_q;
    logic              accept;
    logic              hit;
    logic              is_new;
    logic              is_drop;

    // The output slot frees up when it is empty or popped this cycle,
    // which lets a pop and an accept share one cycle.
    assign in_ready = (state_q == COLLECT)
                   && (!out_valid_q || out_ready)
                   && !clear;
    assign accept   = in_valid && in_ready;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign is_new   = accept && !hit && !full;
    assign is_drop  = accept && !hit && full;

    dedup_cam #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_cam (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .wr_en   (is_new),
        .wr_idx  (count_q),
        .wr_data (in_data),
        .key     (in_data),
        .hit     (hit)
`ifdef STREAM_DEDUP_READBACK_EN
        ,
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_hit  (rd_hit)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (accept && in_last) begin
                    state_d = CLOSED;
                    done_d  = 1'b1;
                end
            end
            CLOSED: begin
                state_d = CLOSED;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
        if (clear) begin
            state_d = COLLECT;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
        end else begin
            if (is_new) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (is_drop) begin
                ovf_q <= 1'b1;
            end
            if (is_new) begin
                out_valid_q <= 1'b1;
                data_q      <= in_data;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = data_q;
    assign unique_count = count_q;
    assign overflow     = ovf_q;
    assign done         = done_q;

endmodule
